// File: rtl/frame_tx_sequencer.sv
// Per-frame sequencer for the parallel output interface: latches configuration,
// streams sample RAM read addresses paced by READ_NEXT, then enforces an inter-frame gap.
module frame_tx_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 12,
  parameter int GAP_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic                  CLR_OVERRUN,
  input  logic [LEN_WIDTH-1:0]  CFG_FRAME_LEN,
  input  logic [ADDR_WIDTH-1:0] CFG_BASE,
  input  logic [GAP_WIDTH-1:0]  CFG_GAP,
  input  logic                  PI_READ_NEXT,
  input  logic                  PI_FRAME_DONE,
  output logic                  PI_RESET,
  output logic [LEN_WIDTH-1:0]  PI_FRAME_LEN,
  output logic                  MEM_RD_EN,
  output logic [ADDR_WIDTH-1:0] MEM_RD_ADDR,
  output logic                  BUSY,
  output logic                  FRAME_DONE_P,
  output logic [CNT_WIDTH-1:0]  FRAME_CNT,
  output logic                  OVERRUN,
  output logic                  ERR
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, GAP} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GAP_WIDTH-1:0]  GAP_ONE   = {{(GAP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH+1:0]  DWELL_ONE = {{(LEN_WIDTH+1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH+1:0]  WD_SLACK  = {{(LEN_WIDTH-1){1'b0}}, 3'd4};

  state_t                  state_reg;
  logic [LEN_WIDTH-1:0]    len_reg;
  logic [LEN_WIDTH-1:0]    issued_reg;
  logic [GAP_WIDTH-1:0]    gap_reg;
  logic [GAP_WIDTH-1:0]    gap_cnt_reg;
  logic [LEN_WIDTH+1:0]    dwell_reg;
  logic [LEN_WIDTH+1:0]    dwell_limit;

  logic                    pi_reset_reg;
  logic [LEN_WIDTH-1:0]    pi_frame_len_reg;
  logic                    rd_en_reg;
  logic [ADDR_WIDTH-1:0]   rd_addr_reg;
  logic                    busy_reg;
  logic                    done_p_reg;
  logic [CNT_WIDTH-1:0]    frame_cnt_reg;
  logic                    overrun_reg;
  logic                    err_reg;

  // Watchdog: a healthy interface finishes well within two cycles per sample.
  assign dwell_limit = {1'b0, len_reg, 1'b0} + WD_SLACK;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg        <= IDLE;
      len_reg          <= '0;
      issued_reg       <= '0;
      gap_reg          <= '0;
      gap_cnt_reg      <= '0;
      dwell_reg        <= '0;
      pi_reset_reg     <= 1'b1;
      pi_frame_len_reg <= '0;
      rd_en_reg        <= 1'b0;
      rd_addr_reg      <= '0;
      busy_reg         <= 1'b0;
      done_p_reg       <= 1'b0;
      frame_cnt_reg    <= '0;
      overrun_reg      <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      err_reg    <= 1'b0;
      done_p_reg <= 1'b0;

      if (START && (state_reg != IDLE)) begin
        overrun_reg <= 1'b1;
      end else if (CLR_OVERRUN) begin
        overrun_reg <= 1'b0;
      end

      if (ABORT) begin
        state_reg    <= IDLE;
        pi_reset_reg <= 1'b1;
        rd_en_reg    <= 1'b0;
        busy_reg     <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            pi_reset_reg <= 1'b1;
            rd_en_reg    <= 1'b0;
            if (START) begin
              if (CFG_FRAME_LEN == '0) begin
                err_reg <= 1'b1;
              end else begin
                len_reg          <= CFG_FRAME_LEN;
                gap_reg          <= CFG_GAP;
                pi_frame_len_reg <= CFG_FRAME_LEN;
                rd_addr_reg      <= CFG_BASE;
                rd_en_reg        <= 1'b1;
                busy_reg         <= 1'b1;
                state_reg        <= LOAD;
              end
            end
          end

          LOAD: begin
            pi_reset_reg <= 1'b0;
            rd_en_reg    <= 1'b0;
            issued_reg   <= '0;
            dwell_reg    <= DWELL_ONE;
            state_reg    <= STREAM;
          end

          STREAM: begin
            dwell_reg <= dwell_reg + DWELL_ONE;
            // The done level left over from the interface reset is stale in the first cycle.
            if (PI_FRAME_DONE && (dwell_reg != DWELL_ONE)) begin
              pi_reset_reg  <= 1'b1;
              rd_en_reg     <= 1'b0;
              frame_cnt_reg <= frame_cnt_reg + CNT_ONE;
              done_p_reg    <= 1'b1;
              gap_cnt_reg   <= gap_reg;
              if (gap_reg != '0) begin
                state_reg <= GAP;
              end else begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end
            end else if (dwell_reg == dwell_limit) begin
              err_reg      <= 1'b1;
              pi_reset_reg <= 1'b1;
              rd_en_reg    <= 1'b0;
              busy_reg     <= 1'b0;
              state_reg    <= IDLE;
            end else if (PI_READ_NEXT && (issued_reg != len_reg)) begin
              rd_en_reg   <= 1'b1;
              rd_addr_reg <= rd_addr_reg + ADDR_ONE;
              issued_reg  <= issued_reg + LEN_ONE;
            end else begin
              rd_en_reg <= 1'b0;
            end
          end

          GAP: begin
            pi_reset_reg <= 1'b1;
            rd_en_reg    <= 1'b0;
            if (gap_cnt_reg == '0) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              gap_cnt_reg <= gap_cnt_reg - GAP_ONE;
            end
          end

          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign PI_RESET     = pi_reset_reg;
  assign PI_FRAME_LEN = pi_frame_len_reg;
  assign MEM_RD_EN    = rd_en_reg;
  assign MEM_RD_ADDR  = rd_addr_reg;
  assign BUSY         = busy_reg;
  assign FRAME_DONE_P = done_p_reg;
  assign FRAME_CNT    = frame_cnt_reg;
  assign OVERRUN      = overrun_reg;
  assign ERR          = err_reg;

endmodule

// File: tb/tb_frame_tx_sequencer.sv
// Bench for frame_tx_sequencer: directed scenarios plus randomized frames checked
// against a transaction-level model (address = base + samples issued, gap timing, counts).
module tb_frame_tx_sequencer;

  localparam int AW = 12;
  localparam int LW = 12;
  localparam int GW = 8;
  localparam int CW = 16;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          START;
  logic          ABORT;
  logic          CLR_OVERRUN;
  logic [LW-1:0] CFG_FRAME_LEN;
  logic [AW-1:0] CFG_BASE;
  logic [GW-1:0] CFG_GAP;
  logic          PI_READ_NEXT;
  logic          PI_FRAME_DONE;
  logic          PI_RESET;
  logic [LW-1:0] PI_FRAME_LEN;
  logic          MEM_RD_EN;
  logic [AW-1:0] MEM_RD_ADDR;
  logic          BUSY;
  logic          FRAME_DONE_P;
  logic [CW-1:0] FRAME_CNT;
  logic          OVERRUN;
  logic          ERR;

  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt = 0;
  bit m_ovr = 1'b0;

  frame_tx_sequencer #(
    .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .GAP_WIDTH(GW), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT), .CLR_OVERRUN(CLR_OVERRUN),
    .CFG_FRAME_LEN(CFG_FRAME_LEN), .CFG_BASE(CFG_BASE), .CFG_GAP(CFG_GAP),
    .PI_READ_NEXT(PI_READ_NEXT), .PI_FRAME_DONE(PI_FRAME_DONE),
    .PI_RESET(PI_RESET), .PI_FRAME_LEN(PI_FRAME_LEN), .MEM_RD_EN(MEM_RD_EN),
    .MEM_RD_ADDR(MEM_RD_ADDR), .BUSY(BUSY), .FRAME_DONE_P(FRAME_DONE_P),
    .FRAME_CNT(FRAME_CNT), .OVERRUN(OVERRUN), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic scramble_cfg();
    CFG_FRAME_LEN = LW'($urandom);
    CFG_BASE      = AW'($urandom);
    CFG_GAP       = GW'($urandom);
  endtask

  // One complete frame; the model tracks samples issued and predicts address/enable/timing.
  task automatic run_frame(input int len, input int base, input int gap, input int rn_mode,
                           input bit poke, input bit clr_poke);
    int issued = 0;
    int k = 1;
    int min_done = (rn_mode == 2) ? len + 3 : 0;
    bit exp_en = 1'b0;
    bit rn;
    bit done = 1'b0;
    CFG_FRAME_LEN = LW'(len);
    CFG_BASE      = AW'(base);
    CFG_GAP       = GW'(gap);
    START = 1'b1;
    step();
    START = 1'b0;
    scramble_cfg();
    chk("load_busy", 32'(BUSY), 1);
    chk("load_pi_reset", 32'(PI_RESET), 1);
    chk("load_rd_en", 32'(MEM_RD_EN), 1);
    chk("load_addr", 32'(MEM_RD_ADDR), base);
    chk("load_frame_len", 32'(PI_FRAME_LEN), len);
    PI_FRAME_DONE = 1'b1;
    PI_READ_NEXT  = 1'b1;
    step();
    while (!done) begin
      chk("stream_pi_reset", 32'(PI_RESET), 0);
      chk("stream_busy", 32'(BUSY), 1);
      chk("stream_addr", 32'(MEM_RD_ADDR), (base + issued) % 4096);
      chk("stream_rd_en", 32'(MEM_RD_EN), 32'(exp_en));
      if (k >= 2)
        done = ((issued == len) && (k >= min_done) && ($urandom_range(0, 1) == 1)) ||
               (k == 2 * len + 3);
      case (rn_mode)
        0:       rn = ($urandom_range(0, 3) != 0);
        1:       rn = ((k & 1) == 1);
        default: rn = 1'b1;
      endcase
      if (done) rn = 1'b0;
      PI_READ_NEXT  = rn;
      PI_FRAME_DONE = (k == 1) || done;
      if (poke && k == 2) begin
        START = 1'b1;
        CLR_OVERRUN = clr_poke;
        m_ovr = 1'b1;
      end
      step();
      START = 1'b0;
      CLR_OVERRUN = 1'b0;
      if (poke && k == 2) chk("overrun_in_stream", 32'(OVERRUN), 1);
      exp_en = rn && (issued < len);
      if (exp_en) issued++;
      k++;
    end
    m_cnt = (m_cnt + 1) % 65536;
    chk("done_pulse", 32'(FRAME_DONE_P), 1);
    chk("done_frame_cnt", 32'(FRAME_CNT), m_cnt);
    chk("done_pi_reset", 32'(PI_RESET), 1);
    chk("done_rd_en", 32'(MEM_RD_EN), 0);
    chk("done_busy", 32'(BUSY), (gap != 0) ? 1 : 0);
    chk("done_addr_hold", 32'(MEM_RD_ADDR), (base + issued) % 4096);
    PI_READ_NEXT  = 1'b0;
    PI_FRAME_DONE = 1'b1;
    for (int j = 1; j <= gap + 1; j++) begin
      if (poke && j == 1 && gap != 0) begin
        START = 1'b1;
        m_ovr = 1'b1;
      end
      step();
      START = 1'b0;
      chk("gap_busy", 32'(BUSY), (j <= gap) ? 1 : 0);
      chk("gap_done_p", 32'(FRAME_DONE_P), 0);
      chk("gap_pi_reset", 32'(PI_RESET), 1);
    end
    chk("frame_overrun", 32'(OVERRUN), 32'(m_ovr));
    chk("frame_cnt_hold", 32'(FRAME_CNT), m_cnt);
    $display("frame len=%0d base=0x%03h gap=%0d mode=%0d issued=%0d cnt=%0d", len, base, gap,
             rn_mode, issued, m_cnt);
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; ABORT = 1'b0; CLR_OVERRUN = 1'b0;
    CFG_FRAME_LEN = '0; CFG_BASE = '0; CFG_GAP = '0;
    PI_READ_NEXT = 1'b0; PI_FRAME_DONE = 1'b1;
    #12;
    chk("rst_pi_reset", 32'(PI_RESET), 1);
    chk("rst_frame_len", 32'(PI_FRAME_LEN), 0);
    chk("rst_rd_en", 32'(MEM_RD_EN), 0);
    chk("rst_addr", 32'(MEM_RD_ADDR), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done_p", 32'(FRAME_DONE_P), 0);
    chk("rst_cnt", 32'(FRAME_CNT), 0);
    chk("rst_overrun", 32'(OVERRUN), 0);
    chk("rst_err", 32'(ERR), 0);
    #1 RESET = 1'b0;
    step();
    chk("idle_busy", 32'(BUSY), 0);

    // Basic frame with toggling READ_NEXT, then the address wrap case.
    run_frame(4, 'h010, 3, 1, 1'b0, 1'b0);
    run_frame(4, 'hFFE, 2, 2, 1'b0, 1'b0);

    // Zero length request.
    CFG_FRAME_LEN = '0; CFG_BASE = AW'('h055); CFG_GAP = GW'(2);
    START = 1'b1;
    step();
    START = 1'b0;
    chk("zlen_err", 32'(ERR), 1);
    chk("zlen_busy", 32'(BUSY), 0);
    chk("zlen_pi_reset", 32'(PI_RESET), 1);
    step();
    chk("zlen_err_pulse", 32'(ERR), 0);
    chk("zlen_busy_after", 32'(BUSY), 0);

    // Overrun: set by START while busy, held, cleared, set beats clear.
    run_frame(6, 'h200, 3, 0, 1'b1, 1'b0);
    step();
    chk("overrun_held", 32'(OVERRUN), 1);
    CLR_OVERRUN = 1'b1;
    step();
    CLR_OVERRUN = 1'b0;
    m_ovr = 1'b0;
    chk("overrun_cleared", 32'(OVERRUN), 0);
    run_frame(6, 'h300, 2, 0, 1'b1, 1'b1);

    // Abort after two of eight samples.
    CFG_FRAME_LEN = LW'(8); CFG_BASE = AW'('h0A0); CFG_GAP = GW'(2);
    START = 1'b1;
    step();
    START = 1'b0;
    PI_READ_NEXT = 1'b1; PI_FRAME_DONE = 1'b1;
    step();
    step();
    PI_FRAME_DONE = 1'b0;
    step();
    chk("abort_pre_addr", 32'(MEM_RD_ADDR), 'h0A2);
    ABORT = 1'b1; PI_READ_NEXT = 1'b0;
    step();
    ABORT = 1'b0;
    chk("abort_busy", 32'(BUSY), 0);
    chk("abort_pi_reset", 32'(PI_RESET), 1);
    chk("abort_rd_en", 32'(MEM_RD_EN), 0);
    chk("abort_done_p", 32'(FRAME_DONE_P), 0);
    chk("abort_cnt", 32'(FRAME_CNT), m_cnt);
    CFG_FRAME_LEN = LW'(3);
    ABORT = 1'b1; START = 1'b1;
    step();
    ABORT = 1'b0; START = 1'b0;
    chk("abort_start_busy", 32'(BUSY), 0);
    chk("abort_start_pi_reset", 32'(PI_RESET), 1);
    step();
    chk("abort_start_busy2", 32'(BUSY), 0);
    chk("abort_start_overrun", 32'(OVERRUN), 32'(m_ovr));
    $display("abort case cnt=%0d", m_cnt);

    // Watchdog: done never arrives after the stale first-cycle level.
    CFG_FRAME_LEN = LW'(5); CFG_BASE = AW'('h040); CFG_GAP = GW'(1);
    START = 1'b1;
    step();
    START = 1'b0;
    PI_FRAME_DONE = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      PI_READ_NEXT = 1'($urandom_range(0, 1));
      step();
      if (c == 1) PI_FRAME_DONE = 1'b0;
    end
    chk("wd_busy_c14", 32'(BUSY), 1);
    chk("wd_err_c14", 32'(ERR), 0);
    step();
    chk("wd_err", 32'(ERR), 1);
    chk("wd_busy", 32'(BUSY), 0);
    chk("wd_pi_reset", 32'(PI_RESET), 1);
    chk("wd_done_p", 32'(FRAME_DONE_P), 0);
    chk("wd_cnt", 32'(FRAME_CNT), m_cnt);
    step();
    chk("wd_err_pulse", 32'(ERR), 0);
    $display("watchdog case cnt=%0d", m_cnt);

    // Randomized frames; configuration inputs are scrambled while busy.
    for (int f = 0; f < 16; f++) begin
      run_frame($urandom_range(1, 12), $urandom_range(0, 4095), $urandom_range(0, 5),
                $urandom_range(0, 2), 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of STREAM, away from any clock edge.
    CFG_FRAME_LEN = LW'(6); CFG_BASE = AW'('h123); CFG_GAP = GW'(2);
    START = 1'b1;
    step();
    START = 1'b0;
    PI_READ_NEXT = 1'b1; PI_FRAME_DONE = 1'b1;
    step();
    step();
    PI_FRAME_DONE = 1'b0;
    #2 RESET = 1'b1;
    #1;
    chk("arst_pi_reset", 32'(PI_RESET), 1);
    chk("arst_frame_len", 32'(PI_FRAME_LEN), 0);
    chk("arst_rd_en", 32'(MEM_RD_EN), 0);
    chk("arst_addr", 32'(MEM_RD_ADDR), 0);
    chk("arst_busy", 32'(BUSY), 0);
    chk("arst_cnt", 32'(FRAME_CNT), 0);
    chk("arst_overrun", 32'(OVERRUN), 0);
    #2 RESET = 1'b0;
    m_cnt = 0;
    m_ovr = 1'b0;
    PI_READ_NEXT = 1'b0; PI_FRAME_DONE = 1'b1;
    step();
    $display("async reset case");
    run_frame(3, 'h7F0, 1, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
